// File: rtl/decoder_proj_pkg.sv
// decoder_proj_pkg: shared code width, code type and debounce FSM states for the decoder project
package decoder_proj_pkg;
   localparam int CODE_W = 7;
   typedef logic [CODE_W-1:0] code_t;
   typedef enum logic [1:0] {IDLE, COUNT, HOLD} deb_state_t;
endpackage

// File: rtl/io_sync_fifo.sv
// io_sync_fifo: WIDTH x DEPTH FIFO with registered head; a push into a full FIFO is dropped
// unless a pop happens on the same edge.
module io_sync_fifo #(
   parameter int WIDTH = 7,
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic [AW:0]      level_o,
   output logic             full_o,
   output logic             drop_o
);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
   logic [AW:0] level_q, level_d;
   logic pop, wr;
   assign pop     = pop_i && level_q != '0;
   assign full_o  = level_q == (AW+1)'(DEPTH);
   // when full, a simultaneous pop frees the slot the write pointer already points at
   assign wr      = push_i && (!full_o || pop);
   assign drop_o  = push_i && full_o && !pop;
   assign rd_d    = pop ? rd_q + 1'b1 : rd_q;
   assign wr_d    = wr ? wr_q + 1'b1 : wr_q;
   assign level_d = level_q + (AW+1)'(wr) - (AW+1)'(pop);
   assign data_o  = mem_q[rd_q];
   assign level_o = level_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         rd_q    <= '0;
         wr_q    <= '0;
         level_q <= '0;
      end else begin
         if (wr) mem_q[wr_q] <= data_i;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         level_q <= level_d;
      end
endmodule

// File: rtl/io_in_sampler.sv
// io_in_sampler: synchronises and word-debounces the io_in pad bus, queueing each newly
// stable code once for the decoder over a valid/ready handshake.
module io_in_sampler
   import decoder_proj_pkg::*;
#(
   parameter int WIDTH           = CODE_W,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int FIFO_DEPTH      = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [WIDTH-1:0]              io_in,
   input  logic                          enable_i,
   output logic [WIDTH-1:0]              code_o,
   output logic                          code_valid_o,
   input  logic                          code_ready_i,
   output logic [$clog2(FIFO_DEPTH):0]   level_o,
   output logic                          overflow_o,
   input  logic                          clear_ovf_i
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
   logic [WIDTH-1:0] chain_q [SYNC_STAGES];
   logic [WIDTH-1:0] sync_q, cand_q, cand_d, last_q, last_d;
   logic [CW-1:0] cnt_q, cnt_d;
   deb_state_t state_q, state_d;
   logic first_q, first_d, ovf_q, ovf_d, push, drop;
   assign sync_q = chain_q[SYNC_STAGES-1];
   always_comb begin
      state_d = state_q;
      cand_d  = cand_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      first_d = first_q;
      push    = 1'b0;
      if (!enable_i || state_q == IDLE || sync_q != cand_q) begin
         state_d = enable_i ? COUNT : IDLE;
         cand_d  = sync_q;
         cnt_d   = '0;
      end else if (state_q == COUNT) begin
         if (cnt_q == CNT_MAX) begin
            state_d = HOLD;
            push    = first_q || cand_q != last_q;
            last_d  = cand_q;
            first_d = 1'b0;
         end else
            cnt_d = cnt_q + 1'b1;
      end
   end
   // a drop in the same cycle as a clear wins, so no overflow is ever lost
   assign ovf_d = drop ? 1'b1 : clear_ovf_i ? 1'b0 : ovf_q;
   assign overflow_o = ovf_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) chain_q[i] <= '0;
         state_q <= IDLE;
         cand_q  <= '0;
         cnt_q   <= '0;
         last_q  <= '0;
         first_q <= 1'b1;
         ovf_q   <= 1'b0;
      end else begin
         chain_q[0] <= io_in;
         for (int i = 1; i < SYNC_STAGES; i++) chain_q[i] <= chain_q[i-1];
         state_q <= state_d;
         cand_q  <= cand_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         first_q <= first_d;
         ovf_q   <= ovf_d;
      end
   io_sync_fifo #(.WIDTH(WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .data_i  (cand_q),
      .pop_i   (code_ready_i),
      .data_o  (code_o),
      .level_o (level_o),
      .full_o  (),
      .drop_o  (drop)
   );
   assign code_valid_o = level_o != '0;
endmodule

// File: tb/tb_io_in_sampler.sv
// tb_io_in_sampler: directed scoreboard bench for io_in_sampler
module tb_io_in_sampler;
   logic clk = 0, rst_n = 0, enable_i = 1, code_ready_i = 0, clear_ovf_i = 0;
   logic [6:0] io_in = 0, code_o;
   logic code_valid_o, overflow_o;
   logic [2:0] level_o;
   logic [6:0] exp_q [$];
   int checks = 0, failures = 0;

   io_in_sampler dut (
      .clk(clk), .rst_n(rst_n), .io_in(io_in), .enable_i(enable_i),
      .code_o(code_o), .code_valid_o(code_valid_o), .code_ready_i(code_ready_i),
      .level_o(level_o), .overflow_o(overflow_o), .clear_ovf_i(clear_ovf_i)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drain(input string tag);
      logic [6:0] e;
      code_ready_i = 1;
      for (int i = 0; i < 16 && code_valid_o; i++) begin
         if (exp_q.size() == 0) check({tag, "_extra"}, 32'(code_o), 32'h80);
         else begin
            e = exp_q.pop_front();
            check({tag, "_pop"}, 32'(code_o), 32'(e));
         end
         tick(1);
      end
      code_ready_i = 0;
      check({tag, "_valid_after"}, 32'(code_valid_o), 0);
      check({tag, "_missing"}, exp_q.size(), 0);
   endtask

   task automatic hold_code(input logic [6:0] c, input bit expect_push);
      io_in = c;
      if (expect_push) exp_q.push_back(c);
      tick(20);
   endtask

   initial begin
      // 1: reset values, then latency of the first code
      io_in = 7'b1001101;
      tick(3);
      check("rst_valid", 32'(code_valid_o), 0);
      check("rst_code", 32'(code_o), 0);
      check("rst_level", 32'(level_o), 0);
      check("rst_ovf", 32'(overflow_o), 0);
      rst_n = 1;
      exp_q.push_back(7'b1001101);
      tick(18);
      check("lat_early", 32'(code_valid_o), 0);
      tick(1);
      check("lat_valid", 32'(code_valid_o), 1);
      check("lat_code", 32'(code_o), 32'h4D);
      check("lat_level", 32'(level_o), 1);
      tick(20);
      check("one_push", 32'(level_o), 1);
      drain("t1");
      // 2: short pulse is never emitted
      hold_code(7'b0000001, 1);
      hold_code(7'b0000001, 0);
      check("t2_level_a", 32'(level_o), 1);
      io_in = 7'b0000010;
      tick(10);
      hold_code(7'b0000001, 0);
      check("t2_level_b", 32'(level_o), 1);
      drain("t2");
      // 3: overflow with ready low, then in-order drain
      hold_code(7'h10, 1);
      hold_code(7'h22, 1);
      hold_code(7'h33, 1);
      hold_code(7'h44, 1);
      check("t3_ovf_before", 32'(overflow_o), 0);
      hold_code(7'h55, 0);
      check("t3_level", 32'(level_o), 4);
      check("t3_ovf", 32'(overflow_o), 1);
      drain("t3");
      // 4: push+pop while full, then clear racing a drop
      clear_ovf_i = 1;
      tick(1);
      clear_ovf_i = 0;
      check("t4_clear", 32'(overflow_o), 0);
      hold_code(7'h60, 1);
      hold_code(7'h61, 1);
      hold_code(7'h62, 1);
      hold_code(7'h63, 1);
      io_in = 7'h64;
      tick(18);
      check("t4_full_pre", 32'(level_o), 4);
      check("t4_head_pre", 32'(code_o), 32'(exp_q.pop_front()));
      exp_q.push_back(7'h64);
      code_ready_i = 1;
      tick(1);
      code_ready_i = 0;
      check("t4_full_post", 32'(level_o), 4);
      check("t4_head_post", 32'(code_o), 32'(exp_q[0]));
      check("t4_no_ovf", 32'(overflow_o), 0);
      io_in = 7'h65;
      tick(18);
      clear_ovf_i = 1;
      tick(1);
      clear_ovf_i = 0;
      check("t4_ovf_prio", 32'(overflow_o), 1);
      check("t4_level_drop", 32'(level_o), 4);
      clear_ovf_i = 1;
      tick(1);
      clear_ovf_i = 0;
      check("t4_clear2", 32'(overflow_o), 0);
      drain("t4");
      // 5: enable dropped mid-count restarts the count
      hold_code(7'h0A, 1);
      io_in = 7'h0B;
      tick(13);
      enable_i = 0;
      tick(6);
      check("t5_idle_level", 32'(level_o), 1);
      check("t5_idle_head", 32'(code_o), 32'h0A);
      enable_i = 1;
      exp_q.push_back(7'h0B);
      tick(16);
      check("t5_early", 32'(level_o), 1);
      tick(1);
      check("t5_push", 32'(level_o), 2);
      drain("t5");
      // 6: async reset mid-count wipes the FIFO; first code re-emitted after release
      hold_code(7'h11, 0);
      hold_code(7'h12, 0);
      check("t6_level", 32'(level_o), 2);
      io_in = 7'h7F;
      tick(8);
      rst_n = 0;
      #1;
      check("t6_async_valid", 32'(code_valid_o), 0);
      check("t6_async_level", 32'(level_o), 0);
      check("t6_async_code", 32'(code_o), 0);
      tick(2);
      rst_n = 1;
      exp_q.push_back(7'h7F);
      tick(18);
      check("t6_early", 32'(code_valid_o), 0);
      tick(1);
      check("t6_reemit", 32'(level_o), 1);
      drain("t6");
      // zero equals the reset value of last_committed, so only first_flag emits it
      io_in = 0;
      tick(3);
      rst_n = 0;
      tick(2);
      rst_n = 1;
      exp_q.push_back(7'h00);
      tick(20);
      check("t6_first_zero", 32'(level_o), 1);
      drain("t6z");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
